// File: rtl/rtc_time_counter_if.sv
// rtl/rtc_time_counter_if.sv - control/status bundle of the RTC time counter
interface rtc_time_counter_if;
  logic       run;
  logic       mode_12h;
  logic       set_valid;
  logic [4:0] set_hh;
  logic [5:0] set_mm;
  logic [5:0] set_ss;
  logic       alm_wr;
  logic [4:0] alm_hh;
  logic [5:0] alm_mm;
  logic       alm_on;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic       pm;
  logic       sec_pulse;
  logic       set_err;
  logic       alarm_hit;

  modport master (
    output run, mode_12h, set_valid, set_hh, set_mm, set_ss,
           alm_wr, alm_hh, alm_mm, alm_on,
    input  seconds, minutes, hours, pm, sec_pulse, set_err, alarm_hit
  );

  modport slave (
    input  run, mode_12h, set_valid, set_hh, set_mm, set_ss,
           alm_wr, alm_hh, alm_mm, alm_on,
    output seconds, minutes, hours, pm, sec_pulse, set_err, alarm_hit
  );
endinterface

// File: rtl/rtc_time_counter.sv
// rtl/rtc_time_counter.sv - prescaled hh:mm:ss counter with set, 12/24 h display and alarm
module rtc_time_counter #(
  parameter int DIV      = 100_000_000,
  parameter bit ALARM_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  rtc_time_counter_if.slave bus
);
  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    ss_q, ss_d, mm_q, mm_d;
  logic [4:0]    hh_q, hh_d;
  logic [4:0]    alm_hh_q, alm_hh_d;
  logic [5:0]    alm_mm_q, alm_mm_d;
  logic          alm_on_q, alm_on_d;
  logic          sec_pulse_q, sec_pulse_d;
  logic          set_err_q, set_err_d;
  logic          alarm_hit_q, alarm_hit_d;

  logic          tick, set_ok, alm_ok;
  logic [5:0]    ss_inc, mm_inc;
  logic [4:0]    hh_inc;

  always_comb begin
    tick   = bus.run && (presc_q == PW'(DIV - 1));
    set_ok = bus.set_valid && (bus.set_hh <= 5'd23) && (bus.set_mm <= 6'd59)
             && (bus.set_ss <= 6'd59);
    alm_ok = bus.alm_wr && (bus.alm_hh <= 5'd23) && (bus.alm_mm <= 6'd59);

    // Carry chain resolves a full 23:59:59 wrap within one edge.
    ss_inc = (ss_q == 6'd59) ? 6'd0 : ss_q + 6'd1;
    mm_inc = mm_q;
    hh_inc = hh_q;
    if (ss_q == 6'd59) begin
      mm_inc = (mm_q == 6'd59) ? 6'd0 : mm_q + 6'd1;
      if (mm_q == 6'd59) hh_inc = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
    end

    presc_d = presc_q;
    ss_d    = ss_q;
    mm_d    = mm_q;
    hh_d    = hh_q;
    if (set_ok) begin
      presc_d = '0;
      ss_d    = bus.set_ss;
      mm_d    = bus.set_mm;
      hh_d    = bus.set_hh;
    end else if (bus.run) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        ss_d = ss_inc;
        mm_d = mm_inc;
        hh_d = hh_inc;
      end
    end

    alm_hh_d = alm_ok ? bus.alm_hh : alm_hh_q;
    alm_mm_d = alm_ok ? bus.alm_mm : alm_mm_q;
    alm_on_d = alm_ok ? bus.alm_on : alm_on_q;

    // A load wins over a coincident tick, so neither pulse fires on a set.
    sec_pulse_d = tick && !set_ok;
    set_err_d   = (bus.set_valid && !set_ok) || (bus.alm_wr && !alm_ok);
    alarm_hit_d = ALARM_EN && tick && !set_ok && alm_on_q && (ss_inc == 6'd0)
                  && (mm_inc == alm_mm_q) && (hh_inc == alm_hh_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q     <= '0;
      ss_q        <= '0;
      mm_q        <= '0;
      hh_q        <= '0;
      alm_hh_q    <= '0;
      alm_mm_q    <= '0;
      alm_on_q    <= 1'b0;
      sec_pulse_q <= 1'b0;
      set_err_q   <= 1'b0;
      alarm_hit_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      ss_q        <= ss_d;
      mm_q        <= mm_d;
      hh_q        <= hh_d;
      alm_hh_q    <= alm_hh_d;
      alm_mm_q    <= alm_mm_d;
      alm_on_q    <= alm_on_d;
      sec_pulse_q <= sec_pulse_d;
      set_err_q   <= set_err_d;
      alarm_hit_q <= alarm_hit_d;
    end
  end

  always_comb begin
    bus.seconds   = ss_q;
    bus.minutes   = mm_q;
    bus.pm        = (hh_q >= 5'd12);
    bus.sec_pulse = sec_pulse_q;
    bus.set_err   = set_err_q;
    bus.alarm_hit = alarm_hit_q;
    if (!bus.mode_12h)      bus.hours = hh_q;
    else if (hh_q == 5'd0)  bus.hours = 5'd12;
    else if (hh_q > 5'd12)  bus.hours = hh_q - 5'd12;
    else                    bus.hours = hh_q;
  end
endmodule
